// File: rtl/layer_stream_sequencer.sv
// layer_stream_sequencer
// Captures a producing layer's parallel output vector when every per-neuron
// valid bit is high, then streams it one word per cycle (lowest word first)
// to the consuming layer under a valid/ready handshake. A one-vector holding
// slot absorbs a capture that arrives mid-stream; a capture that finds the
// slot full is dropped and raises a sticky overflow flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_vec     producing-layer outputs, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   per-neuron valid bits; all high = capture event
//   out_ready  consumer accepts the current word
//   clr_ovf    synchronous clear of overflow (a same-cycle drop wins)
//   out_word   current streamed word
//   out_valid  out_word is valid
//   out_last   final word of the vector
//   out_idx    index of the current word within its vector
//   next_valid replicated handshake strobe for the consuming layer
//   busy       streaming or holding slot occupied
//   vec_done   one-cycle pulse after the last word is accepted
//   overflow   sticky: a captured vector was dropped
module layer_stream_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_IN       = 40,
  parameter int unsigned N_NEXT     = 30,
  localparam int unsigned IDX_W     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*DATA_WIDTH-1:0] in_vec,
  input  logic [N_IN-1:0]            in_valid,
  input  logic                       out_ready,
  input  logic                       clr_ovf,
  output logic [DATA_WIDTH-1:0]      out_word,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [IDX_W-1:0]           out_idx,
  output logic [N_NEXT-1:0]          next_valid,
  output logic                       busy,
  output logic                       vec_done,
  output logic                       overflow
);

  localparam int unsigned VEC_W = N_IN * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(N_IN + 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   buf_q, buf_d;
  logic [VEC_W-1:0]   slot_q, slot_d;
  logic               slot_full_q, slot_full_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               vec_done_q, vec_done_d;
  logic               ovf_q, ovf_d;

  logic cap;
  logic hs;
  logic last_hs;

  assign cap     = &in_valid;
  assign hs      = out_valid & out_ready;
  assign last_hs = hs & (cnt_q == CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    slot_d      = slot_q;
    slot_full_d = slot_full_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    vec_done_d  = 1'b0;
    ovf_d       = clr_ovf ? 1'b0 : ovf_q;

    unique case (state_q)
      StIdle: begin
        if (cap) begin
          buf_d   = in_vec;
          cnt_d   = CNT_W'(N_IN);
          idx_d   = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (last_hs) begin
          vec_done_d = 1'b1;
          if (slot_full_q) begin
            // Held vector follows with no bubble; a coincident capture
            // refills the slot it just vacated.
            buf_d = slot_q;
            cnt_d = CNT_W'(N_IN);
            idx_d = '0;
            if (cap) begin
              slot_d = in_vec;
            end else begin
              slot_full_d = 1'b0;
            end
          end else if (cap) begin
            buf_d = in_vec;
            cnt_d = CNT_W'(N_IN);
            idx_d = '0;
          end else begin
            buf_d   = '0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = StIdle;
          end
        end else begin
          if (hs) begin
            buf_d = buf_q >> DATA_WIDTH;
            cnt_d = cnt_q - CNT_W'(1);
            idx_d = idx_q + IDX_W'(1);
          end
          if (cap) begin
            if (!slot_full_q) begin
              slot_d      = in_vec;
              slot_full_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      slot_q      <= '0;
      slot_full_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      vec_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      slot_q      <= slot_d;
      slot_full_q <= slot_full_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      vec_done_q  <= vec_done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_word   = buf_q[DATA_WIDTH-1:0];
  assign out_valid  = (state_q == StStream);
  assign out_last   = out_valid & (cnt_q == CNT_W'(1));
  assign out_idx    = idx_q;
  assign next_valid = {N_NEXT{hs}};
  assign busy       = (state_q == StStream) | slot_full_q;
  assign vec_done   = vec_done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Testbench for layer_stream_sequencer: directed scenarios plus a randomized
// run checked against a word-queue reference model.
module tb_layer_stream_sequencer;

  localparam int DW = 16;
  localparam int N  = 40;
  localparam int NN = 30;
  localparam int IW = 6;
  localparam int RW = DW + IW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_vec;
  logic [N-1:0]    in_valid;
  logic            out_ready;
  logic            clr_ovf;
  logic [DW-1:0]   out_word;
  logic            out_valid;
  logic            out_last;
  logic [IW-1:0]   out_idx;
  logic [NN-1:0]   next_valid;
  logic            busy;
  logic            vec_done;
  logic            overflow;

  layer_stream_sequencer #(
    .DATA_WIDTH(DW),
    .N_IN      (N),
    .N_NEXT    (NN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .next_valid(next_valid),
    .busy      (busy),
    .vec_done  (vec_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitor: logs every handshake, vec_done pulse, next_valid strobe and
  // any stalled word that changed before it was accepted.
  int             cyc_n    = 0;
  logic [RW-1:0]  hs_rec[$];
  int             hs_cyc[$];
  int             done_cyc[$];
  int             nv_cnt   = 0;
  int             hold_err = 0;
  logic           stall_q  = 1'b0;
  logic [DW-1:0]  stall_word = '0;

  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (stall_q && rst && (out_valid !== 1'b1 || out_word !== stall_word))
      hold_err <= hold_err + 1;
    stall_q    <= out_valid & ~out_ready;
    stall_word <= out_word;
    if (out_valid && out_ready) begin
      hs_rec.push_back({out_word, out_idx, out_last});
      hs_cyc.push_back(cyc_n);
    end
    if (vec_done) done_cyc.push_back(cyc_n);
    if (next_valid === {NN{1'b1}}) nv_cnt <= nv_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input int base);
    for (int i = 0; i < N; i++) in_vec[i*DW +: DW] = DW'(base + i);
  endtask

  task automatic cap_pulse();
    in_valid = '1;
    cyc();
    in_valid = '0;
  endtask

  // Expected handshake record for word i of a vector whose word 0 is base.
  function automatic logic [RW-1:0] rec_of(input int base, input int i);
    logic l;
    l = (i == N - 1);
    return {DW'(base + i), IW'(i), l};
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_vec = '0; in_valid = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    tests_run++;
    if ({out_valid, out_last, busy, vec_done, overflow} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000",
               {out_valid, out_last, busy, vec_done, overflow});
    end
    tests_run++;
    if (out_word !== '0 || out_idx !== '0 || next_valid !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: word=%h idx=%0d nv=%h expected all 0",
               out_word, out_idx, next_valid);
    end
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    int b, db, nb, n;
    logic [RW-1:0] ex[$];
    b = hs_rec.size(); db = done_cyc.size(); nb = nv_cnt;
    for (int i = 0; i < N; i++) ex.push_back(rec_of(1, i));
    out_ready = 1'b1;
    load_vec(1);
    cap_pulse();
    tests_run++;
    if (out_valid !== 1'b1 || out_word !== 16'd1 || out_idx !== '0) begin
      tests_failed++;
      $display("FAIL single_latency: valid=%b word=%0d idx=%0d expected 1,1,0",
               out_valid, out_word, out_idx);
    end
    repeat (45) cyc();
    n = hs_rec.size() - b;
    tests_run++;
    if (n != N) begin
      tests_failed++;
      $display("FAIL single_count: got %0d handshakes expected %0d", n, N);
    end
    for (int i = 0; i < n && i < N; i++) begin
      tests_run++;
      if (hs_rec[b+i] !== ex[i] || hs_cyc[b+i] != hs_cyc[b] + i) begin
        tests_failed++;
        $display("FAIL single_word[%0d]: got %h at cyc %0d expected %h at cyc %0d",
                 i, hs_rec[b+i], hs_cyc[b+i], ex[i], hs_cyc[b] + i);
      end
    end
    tests_run++;
    if (done_cyc.size() - db != 1 || n != N || done_cyc[db] != hs_cyc[b+N-1] + 1) begin
      tests_failed++;
      $display("FAIL single_vec_done: got %0d pulses expected 1 pulse one cycle after last",
               done_cyc.size() - db);
    end
    tests_run++;
    if (nv_cnt - nb != N) begin
      tests_failed++;
      $display("FAIL single_next_valid: got %0d strobes expected %0d", nv_cnt - nb, N);
    end
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: busy=%b valid=%b expected 0,0", busy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int b, db, he, nb, n;
    logic [RW-1:0] ex[$];
    b = hs_rec.size(); db = done_cyc.size(); he = hold_err; nb = nv_cnt;
    for (int i = 0; i < N; i++) ex.push_back(rec_of(1, i));
    out_ready = 1'b0;
    load_vec(1);
    cap_pulse();
    for (int i = 0; i < 100; i++) begin
      out_ready = (i % 2 == 0);
      cyc();
    end
    out_ready = 1'b1;
    n = hs_rec.size() - b;
    tests_run++;
    if (n != N) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d handshakes expected %0d", n, N);
    end
    for (int i = 0; i < n && i < N; i++) begin
      tests_run++;
      if (hs_rec[b+i] !== ex[i]) begin
        tests_failed++;
        $display("FAIL bp_word[%0d]: got %h expected %h", i, hs_rec[b+i], ex[i]);
      end
    end
    tests_run++;
    if (hold_err != he || nv_cnt - nb != N || done_cyc.size() - db != 1) begin
      tests_failed++;
      $display("FAIL bp_hold: hold_err=%0d strobes=%0d done=%0d expected 0,%0d,1",
               hold_err - he, nv_cnt - nb, done_cyc.size() - db, N);
    end
  endtask

  task automatic test_back_to_back();
    int b, db, n;
    logic [RW-1:0] ex[$];
    b = hs_rec.size(); db = done_cyc.size();
    for (int i = 0; i < N; i++) ex.push_back(rec_of(1, i));
    for (int i = 0; i < N; i++) ex.push_back(rec_of(100, i));
    out_ready = 1'b1;
    load_vec(1);
    cap_pulse();
    repeat (10) cyc();
    load_vec(100);
    cap_pulse();
    tests_run++;
    if (busy !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_slot: busy=%b overflow=%b expected 1,0", busy, overflow);
    end
    repeat (4) cyc();
    load_vec(200);
    cap_pulse();
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    repeat (80) cyc();
    n = hs_rec.size() - b;
    tests_run++;
    if (n != 2 * N) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d handshakes expected %0d", n, 2 * N);
    end
    for (int i = 0; i < n && i < 2 * N; i++) begin
      tests_run++;
      if (hs_rec[b+i] !== ex[i] || hs_cyc[b+i] != hs_cyc[b] + i) begin
        tests_failed++;
        $display("FAIL b2b_word[%0d]: got %h at cyc %0d expected %h at cyc %0d",
                 i, hs_rec[b+i], hs_cyc[b+i], ex[i], hs_cyc[b] + i);
      end
    end
    tests_run++;
    if (overflow !== 1'b1 || busy !== 1'b0 || done_cyc.size() - db != 2) begin
      tests_failed++;
      $display("FAIL b2b_end: overflow=%b busy=%b done=%0d expected 1,0,2",
               overflow, busy, done_cyc.size() - db);
    end
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    // Drop coinciding with clr_ovf: the set must win.
    load_vec(1);
    cap_pulse();
    repeat (2) cyc();
    load_vec(100);
    cap_pulse();
    load_vec(200);
    in_valid = '1;
    clr_ovf  = 1'b1;
    cyc();
    in_valid = '0;
    clr_ovf  = 1'b0;
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_priority: got %b expected 1", overflow);
    end
    repeat (90) cyc();
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
  endtask

  task automatic test_coincident();
    int b, n;
    logic [RW-1:0] ex[$];
    for (int i = 0; i < N; i++) ex.push_back(rec_of(1, i));
    for (int i = 0; i < N; i++) ex.push_back(rec_of(300, i));
    b = hs_rec.size();
    out_ready = 1'b1;
    load_vec(1);
    cap_pulse();
    repeat (N - 1) cyc();
    load_vec(300);
    cap_pulse();
    tests_run++;
    if (out_valid !== 1'b1 || out_word !== 16'd300 || out_idx !== '0 || out_last !== 1'b0
        || vec_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL coinc_reload: valid=%b word=%0d idx=%0d last=%b done=%b expected 1,300,0,0,1",
               out_valid, out_word, out_idx, out_last, vec_done);
    end
    repeat (45) cyc();
    n = hs_rec.size() - b;
    tests_run++;
    if (n != 2 * N || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL coinc_count: got %0d handshakes ovf=%b expected %0d,0", n, overflow, 2 * N);
    end
    for (int i = 0; i < n && i < 2 * N; i++) begin
      tests_run++;
      if (hs_rec[b+i] !== ex[i] || hs_cyc[b+i] != hs_cyc[b] + i) begin
        tests_failed++;
        $display("FAIL coinc_word[%0d]: got %h expected %h", i, hs_rec[b+i], ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b, db, n;
    logic [RW-1:0] ex[$];
    for (int i = 0; i < N; i++) ex.push_back(rec_of(500, i));
    db = done_cyc.size();
    out_ready = 1'b1;
    load_vec(1);
    cap_pulse();
    repeat (17) cyc();
    tests_run++;
    if (out_idx !== IW'(17) || out_word !== 16'd18) begin
      tests_failed++;
      $display("FAIL rstmid_pos: idx=%0d word=%0d expected 17,18", out_idx, out_word);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || vec_done !== 1'b0 || out_idx !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_async: valid=%b busy=%b done=%b idx=%0d expected 0,0,0,0",
               out_valid, busy, vec_done, out_idx);
    end
    cyc();
    rst = 1'b1;
    cyc();
    tests_run++;
    if (done_cyc.size() != db) begin
      tests_failed++;
      $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cyc.size() - db);
    end
    b = hs_rec.size();
    load_vec(500);
    cap_pulse();
    repeat (45) cyc();
    n = hs_rec.size() - b;
    tests_run++;
    if (n != N || done_cyc.size() - db != 1) begin
      tests_failed++;
      $display("FAIL rstmid_fresh: got %0d handshakes %0d done expected %0d,1",
               n, done_cyc.size() - db, N);
    end
    for (int i = 0; i < n && i < N; i++) begin
      tests_run++;
      if (hs_rec[b+i] !== ex[i]) begin
        tests_failed++;
        $display("FAIL rstmid_word[%0d]: got %h expected %h", i, hs_rec[b+i], ex[i]);
      end
    end
  endtask

  // Reference model: words still to be streamed in order, words left in the
  // current vector, whether a second vector is waiting, sticky overflow and
  // the pending done pulse.
  task automatic test_random();
    logic [DW-1:0] wq[$];
    int   rem;
    bit   held, m_ovf, m_done, capv, hsv, lasths, drop;
    rst = 1'b0; in_valid = '0; clr_ovf = 1'b0;
    #1;
    cyc();
    rst = 1'b1;
    rem = 0; held = 0; m_ovf = 0; m_done = 0;
    for (int c = 0; c < 2500; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) in_vec[i*DW +: DW] = DW'($urandom());
      if ($urandom_range(0, 11) == 0) begin
        in_valid = '1;
      end else begin
        in_valid = N'({$urandom(), $urandom()});
        in_valid[$urandom_range(0, N - 1)] = 1'b0;
      end
      #1;
      tests_run++;
      if (out_valid !== (rem > 0) || busy !== (rem > 0 || held)) begin
        tests_failed++;
        $display("FAIL rnd_valid_busy c%0d: got %b%b expected %b%b",
                 c, out_valid, busy, rem > 0, rem > 0 || held);
      end
      if (rem > 0) begin
        tests_run++;
        if (out_word !== wq[0] || out_idx !== IW'(N - rem) || out_last !== (rem == 1)) begin
          tests_failed++;
          $display("FAIL rnd_word c%0d: got %h/%0d/%b expected %h/%0d/%b",
                   c, out_word, out_idx, out_last, wq[0], N - rem, rem == 1);
        end
      end
      tests_run++;
      if (vec_done !== m_done || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL rnd_done_ovf c%0d: got %b%b expected %b%b",
                 c, vec_done, overflow, m_done, m_ovf);
      end
      tests_run++;
      if (next_valid !== ((rem > 0 && out_ready) ? {NN{1'b1}} : {NN{1'b0}})) begin
        tests_failed++;
        $display("FAIL rnd_next_valid c%0d: got %h", c, next_valid);
      end
      capv   = (in_valid === {N{1'b1}});
      hsv    = (rem > 0) && out_ready;
      lasths = hsv && rem == 1;
      drop   = 0;
      if (hsv) begin
        void'(wq.pop_front());
        rem--;
      end
      if (lasths && held) begin
        rem  = N;
        held = 0;
      end
      if (capv) begin
        if (rem == 0) begin
          for (int i = 0; i < N; i++) wq.push_back(in_vec[i*DW +: DW]);
          rem = N;
        end else if (!held) begin
          for (int i = 0; i < N; i++) wq.push_back(in_vec[i*DW +: DW]);
          held = 1;
        end else begin
          drop = 1;
        end
      end
      m_done = lasths;
      m_ovf  = drop ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
      cyc();
    end
    in_valid = '0;
    clr_ovf  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
